// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus widths, defaults and index helper for the bus arbiter
package bus_arbiter_pkg;

    localparam int BUS_DATA_W    = 24;
    localparam int BUS_N_MASTER  = 4;
    localparam int BUS_ID_W      = 2;
    localparam int BUS_BURST_LEN = 4;

    // Modulo-n increment of a master index (n need not be a power of two)
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational rotate-priority encoder (rr_pick)
module rr_pick #(
    parameter int N_MASTER = 4,
    parameter int ID_W     = 2
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [ID_W-1:0]     ptr,
    output logic [N_MASTER-1:0] gnt_onehot,
    output logic [ID_W-1:0]     gnt_idx
);

    // First requester at or above ptr, wrapping from N_MASTER-1 back to 0
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            idx = (32'(ptr) + 32'(k)) % 32'(N_MASTER);
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin N-to-1 arbiter with registered output slice; burst hold under BUS_ARB_BURST_EN
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTER  = BUS_N_MASTER,
    parameter int DATA_W    = BUS_DATA_W,
    parameter int ID_W      = BUS_ID_W,
    parameter int BURST_LEN = BUS_BURST_LEN
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [N_MASTER-1:0]        m_valid,
    input  logic [N_MASTER*DATA_W-1:0] m_data,
    output logic [N_MASTER-1:0]        m_ready,
    output logic                       s_valid,
    output logic [DATA_W-1:0]          s_data,
    output logic [ID_W-1:0]            s_id,
    input  logic                       s_ready,
    output logic                       arb_busy
);

    logic                s_valid_q, s_valid_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [ID_W-1:0]     s_id_q, s_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_MASTER-1:0] gnt_onehot;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     gnt_next;
    logic                load;
    logic                xfer;

    rr_pick #(
        .N_MASTER (N_MASTER),
        .ID_W     (ID_W)
    ) u_pick (
        .req        (m_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Slot can take a beat when empty or when its current beat leaves this cycle
    always_comb begin
        load     = ~s_valid_q | s_ready;
        m_ready  = (load && !RST) ? gnt_onehot : '0;
        xfer     = |m_ready;
        gnt_next = ID_W'(wrap_inc(32'(gnt_idx), 32'(N_MASTER)));
        arb_busy = s_valid_q | (|m_valid);
    end

    // Output slice: load winner, drain when consumed, otherwise hold
    always_comb begin
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_id_d    = s_id_q;
        if (xfer) begin
            s_valid_d = 1'b1;
            s_data_d  = m_data[32'(gnt_idx)*DATA_W +: DATA_W];
            s_id_d    = gnt_idx;
        end else if (s_valid_q && s_ready) begin
            s_valid_d = 1'b0;
        end
    end

`ifdef BUS_ARB_BURST_EN
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] cnt_next;

    // Winner keeps the pointer for up to BURST_LEN beats; a non-zero count means ptr_q is the owner
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        cnt_next = 4'd1;
        if (xfer) begin
            if (cnt_q != 3'd0 && gnt_idx == ptr_q) begin
                cnt_next = {1'b0, cnt_q} + 4'd1;
            end
            if (cnt_next == 4'(BURST_LEN)) begin
                cnt_d = 3'd0;
                ptr_d = gnt_next;
            end else begin
                cnt_d = cnt_next[2:0];
                ptr_d = gnt_idx;
            end
        end else if (cnt_q != 3'd0 && !m_valid[ptr_q]) begin
            cnt_d = 3'd0;
            ptr_d = ID_W'(wrap_inc(32'(ptr_q), 32'(N_MASTER)));
        end
    end

    // Burst counter register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Pure round-robin: pointer moves past every winner
    always_comb begin
        ptr_d = xfer ? gnt_next : ptr_q;
    end
`endif

    // Slice and pointer registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_id_q    <= '0;
            ptr_q     <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_id_q    <= s_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign s_valid = s_valid_q;
    assign s_data  = s_data_q;
    assign s_id    = s_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = BUS_N_MASTER;
    localparam int DW = BUS_DATA_W;
    localparam int IW = BUS_ID_W;
    localparam int BL = BUS_BURST_LEN;

    logic            clk = 1'b0;
    logic            RST;
    logic [N-1:0]    m_valid;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic [IW-1:0]   s_id;
    logic            s_ready;
    logic            arb_busy;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int            mptr;
    int            bown;
    int            bcnt;
    bit            e_valid;
    logic [DW-1:0] e_data;
    int            e_id;
    logic [N-1:0]  acc;
    int            seq [N];

    bus_arbiter dut (
        .clk      (clk),
        .RST      (RST),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_id     (s_id),
        .s_ready  (s_ready),
        .arb_busy (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (m_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        if (RST) return r;
        if (e_valid && !s_ready) return r;
        w = winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        mptr = 0; bown = 0; bcnt = 0;
        e_valid = 1'b0; e_data = '0; e_id = 0; acc = '0;
    endtask

    task automatic model_edge();
        int w;
        acc = '0;
        if (RST) begin
            model_reset();
            return;
        end
        w = (exp_ready() != '0) ? winner() : -1;
        if (w >= 0) begin
            acc[w]  = 1'b1;
            e_valid = 1'b1;
            e_data  = m_data[w*DW +: DW];
            e_id    = w;
`ifdef BUS_ARB_BURST_EN
            if (bcnt > 0 && w == bown) bcnt++;
            else begin
                bcnt = 1;
                bown = w;
            end
            if (bcnt == BL) begin
                bcnt = 0;
                mptr = (w + 1) % N;
            end else begin
                mptr = w;
            end
`else
            mptr = (w + 1) % N;
`endif
        end else begin
            if (e_valid && s_ready) e_valid = 1'b0;
`ifdef BUS_ARB_BURST_EN
            if (bcnt > 0 && !m_valid[bown]) begin
                bcnt = 0;
                mptr = (bown + 1) % N;
            end
`endif
        end
    endtask

    // one clock: compare away from the edge, advance the model at the edge
    task automatic cycle();
        @(negedge clk);
        chk("m_ready", 32'(m_ready), 32'(exp_ready()));
        chk("arb_busy", 32'(arb_busy), 32'(e_valid | (|m_valid)));
        chk("s_valid", 32'(s_valid), 32'(e_valid));
        chk("s_data", 32'(s_data), 32'(e_data));
        chk("s_id", 32'(s_id), 32'(e_id));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        RST = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        m_data[i*DW +: DW] = d;
    endtask

    initial begin
        int rr_ids [6];
        int wr_ids [3];
        int bu_ids [9];
        rr_ids = '{0, 1, 2, 3, 0, 1};
        wr_ids = '{0, 2, 0};
        bu_ids = '{0, 0, 0, 0, 1, 1, 1, 1, 2};

        // reset held over two edges with all masters requesting
        RST = 1'b1;
        m_valid = '1;
        m_data = '0;
        s_ready = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) seq[i] = 0;
        @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_s_id", 32'(s_id), 32'd0);
        @(posedge clk);
        chk("rst_m_ready_edge", 32'(m_ready), 32'd0);
        #1;
        RST = 1'b0;

        // single master, 1-cycle latency
        m_valid = 4'b0001;
        set_data(0, 24'hA5A5A5);
        cycle();
        chk("single_valid", 32'(s_valid), 32'd1);
        chk("single_data", 32'(s_data), 32'h00A5A5A5);
        chk("single_id", 32'(s_id), 32'd0);
        m_valid = '0;
        cycle();
        chk("drain_valid", 32'(s_valid), 32'd0);
        chk("drain_hold_data", 32'(s_data), 32'h00A5A5A5);

        do_reset();
`ifdef BUS_ARB_BURST_EN
        m_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, DW'(i + 1));
        for (int c = 0; c < 9; c++) begin
            cycle();
            chk("burst_id", 32'(s_id), 32'(bu_ids[c]));
        end
`else
        // round robin, one beat per cycle
        m_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, DW'(i + 1));
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("rr_id", 32'(s_id), 32'(rr_ids[c]));
            chk("rr_data", 32'(s_data), 32'(rr_ids[c] + 1));
        end

        // backpressure: slot frozen for 3 cycles, pointer held
        m_valid = 4'b0001;
        set_data(0, 24'h111111);
        cycle();
        s_ready = 1'b0;
        m_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, DW'(i + 2));
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("bp_data", 32'(s_data), 32'h00111111);
            chk("bp_m_ready", 32'(m_ready), 32'd0);
        end
        s_ready = 1'b1;
        cycle();
        chk("bp_next_id", 32'(s_id), 32'd1);
        chk("bp_next_data", 32'(s_data), 32'd3);

        // wrap and skip from pointer 3
        m_valid = 4'b0100;
        cycle();
        m_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("wrap_id", 32'(s_id), 32'(wr_ids[c]));
        end
`endif

        // asynchronous reset while stalled with a beat in the slot
        m_valid = 4'b0001;
        s_ready = 1'b0;
        cycle();
        chk("stall_pre_valid", 32'(s_valid), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", 32'(s_valid), 32'd0);
        chk("async_rst_ready", 32'(m_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        RST = 1'b0;

        // randomized traffic with backpressure; masters hold beats until accepted
        m_valid = '0;
        acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !m_valid[i]) begin
                    m_valid[i] = ($urandom_range(0, 99) < 70);
                    seq[i]++;
                    set_data(i, DW'({8'(i), 16'(seq[i])}));
                end
            end
            s_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        m_valid = '0;
        s_ready = 1'b1;
        cycle();
        cycle();
        chk("final_idle", 32'(s_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
